if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage directly upstream of ID: owns the PC, issues fetches to instruction memory
//  over a req/gnt + rvalid handshake, and buffers returned words. Hands {inst, pc, pc+4} to ID with a
//  valid/ready handshake (id_inst -> ID din, id_pc4 -> ID npc_pc4). Redirects from EX/branch flush it.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset release
//  BUF_DEPTH  2              fetch-buffer entries, power of two, >= 2; bounds in-flight + buffered fetches
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous reset, active low
//  imem_req     out  1   fetch request; held until imem_gnt
//  imem_addr    out  32  fetch address, word aligned; stable while imem_req && !imem_gnt
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   in-order read response valid (>= 1 cycle after its gnt)
//  imem_rdata   in   32  instruction word
//  id_valid     out  1   id_inst/id_pc/id_pc4 valid
//  id_ready     in   1   ID accepts this cycle
//  id_inst      out  32  instruction
//  id_pc        out  32  its address
//  id_pc4       out  32  id_pc + 4
//  redirect     in   1   flush + restart fetch
//  redirect_pc  in   32  new PC; bits [1:0] cleared internally
// BEHAVIOUR
//  - Reset (async, rst_n=0): fetch pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_valid=0,
//    id_inst/id_pc/id_pc4=0, buffer empty, in-flight=0, drop count=0. First imem_req 1 cycle after release.
//  - Credit: imem_req asserted when (buffered + in_flight) < BUF_DEPTH. On gnt: slot allocated, tagged
//    with imem_addr; pc <= pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0); in_flight++.
//  - Response: imem_rvalid fills oldest unfilled slot (in order), in_flight--. If drop count > 0 the
//    response is discarded instead and drop count--.
//  - Output: id_valid = head slot filled; registered outputs mirror head. Pop on id_valid && id_ready;
//    new head visible next cycle. Full buffer: imem_req deasserts; no overflow, no data loss.
//  - Redirect (cycle t): all slots cleared; drop count += in_flight (incl. a gnt in cycle t, incl. rvalid
//    not yet arrived); an rvalid in cycle t is dropped; a pop in cycle t has no effect; id_valid=0 at t+1;
//    pc <= {redirect_pc[31:2],2'b00}. An ungranted request pending at t stays stable until gnt, then counts
//    as a drop. Earliest new-PC imem_req at t+1; with gnt same cycle and rvalid next, id_valid at t+3.
//  - Redirect + full buffer: buffer empties, issue resumes once credit allows (drops consume credit).
//  - Back-to-back redirects: latest redirect_pc wins; drop counts accumulate.
//  - Steady state with 1-cycle imem and id_ready=1: one instruction per cycle.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (pops), perf_stall_cnt[31:0] (cycles with
//    id_valid && !id_ready), perf_flush_cnt[31:0] (redirects); reset 0, wrap at 2^32, saturation none.
//  Undefined: those ports and counters absent; all other behaviour identical.
// STRUCTURE
//  defines.vh: IMEM_WORD_BYTES (4), PC_ALIGN_MASK (32'hFFFF_FFFC), RESET_PC default value.
//  Sub-module if_fetch_buf: BUF_DEPTH-slot circular buffer {pc, inst, filled}, alloc/fill/pop/flush ports,
//    pointers log2(BUF_DEPTH) bits + wrap bit for full/empty. Top holds pc, credit, drop counter, handshakes.
// TESTING
//  1 Reset release, 1-cycle imem, id_ready=1 -> addrs 0,4,8,... ; id_pc4 = id_pc+4; 1 inst/cycle.
//  2 id_ready=0 for 5 cycles -> exactly BUF_DEPTH (2) grants, imem_req low, no word lost or repeated.
//  3 redirect_pc=32'h0000_0103 with 2 fetches in flight -> both responses dropped, next id_pc=32'h100.
//  4 gnt withheld 3 cycles -> imem_addr stable; redirect during wait -> that fetch dropped after gnt.
//  5 RESET_PC=32'hFFFF_FFF8 -> id_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6 rst_n low mid-stream with rvalid pending -> all outputs to reset values same cycle; restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
//   IMEM_WORD_BYTES  : bytes per instruction word (PC step)
//   PC_ALIGN_MASK    : clears the byte offset of a fetch address
//   RESET_PC_DEFAULT : default first fetch address after reset
package if_fetch_pkg;
  localparam int unsigned IMEM_WORD_BYTES  = 4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction
endpackage

// File: rtl/if_fetch_buf.sv
// In-order fetch buffer, DEPTH slots of {pc, inst}.
// A slot is allocated at grant (pc known), filled at response (inst known)
// and popped by ID. Three pointers with an extra wrap bit:
//   tail : next slot to allocate
//   fptr : oldest allocated-but-unfilled slot (slot filled <=> behind fptr)
//   head : oldest slot, valid to ID once filled
// Ports: flush clears every slot; alloc/alloc_pc, fill/fill_inst, pop;
//        head_vld/head_pc/head_inst describe the head; count = allocated
//        slots, unfilled = allocated slots still waiting for data.
module if_fetch_buf #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        alloc,
  input  logic [31:0] alloc_pc,
  input  logic        fill,
  input  logic [31:0] fill_inst,
  input  logic        pop,
  output logic        head_vld,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst,
  output logic [PW:0] count,
  output logic [PW:0] unfilled
);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [PW:0] head_q, head_d, fptr_q, fptr_d, tail_q, tail_d;
  logic [DEPTH-1:0][31:0] pc_mem_q, inst_mem_q;
  logic alloc_ok, fill_ok, pop_ok;

  assign alloc_ok = alloc && !flush;
  // a response with no slot waiting for it is ignored rather than corrupting order
  assign fill_ok  = fill && !flush && (fptr_q != tail_q);
  assign pop_ok   = pop && !flush && head_vld;

  always_comb begin
    head_d = head_q;
    fptr_d = fptr_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      fptr_d = '0;
      tail_d = '0;
    end else begin
      if (alloc_ok) tail_d = tail_q + PTR_ONE;
      if (fill_ok)  fptr_d = fptr_q + PTR_ONE;
      if (pop_ok)   head_d = head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      fptr_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      fptr_q <= fptr_d;
      tail_q <= tail_d;
    end
  end

  // payload storage needs no reset: nothing is read until its pointer says so
  always_ff @(posedge clk) begin
    if (alloc_ok) pc_mem_q[tail_q[PW-1:0]]   <= alloc_pc;
    if (fill_ok)  inst_mem_q[fptr_q[PW-1:0]] <= fill_inst;
  end

  assign head_vld  = (fptr_q != head_q);
  assign head_pc   = pc_mem_q[head_q[PW-1:0]];
  assign head_inst = inst_mem_q[head_q[PW-1:0]];
  assign count     = tail_q - head_q;
  assign unfilled  = tail_q - fptr_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/gnt +
// in-order rvalid handshake, buffers returned words and hands {inst, pc, pc+4}
// to ID over valid/ready. A redirect flushes the buffer and restarts fetch.
// Ports: clk, rst_n (async, active low); imem_req/imem_addr/imem_gnt,
//        imem_rvalid/imem_rdata; id_valid/id_ready/id_inst/id_pc/id_pc4;
//        redirect/redirect_pc.
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt, perf_stall_cnt and
//           perf_flush_cnt (free-running, wrapping 32-bit counters).
module if_fetch_stage
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);
  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          run_q, run_d;
  logic          hold_q, hold_d;       // request pending, not yet granted
  logic          stale_q, stale_d;     // pending request predates a redirect
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic [CW-1:0] drop_q, drop_d;       // in-flight responses to discard

  logic [CW-1:0] buf_cnt, buf_unfilled;
  logic          head_vld;
  logic [31:0]   head_pc, head_inst;
  logic [CW:0]   used;
  logic          pop, credit_ok, gnt_fire, gnt_drop, alloc, fill;

  // credit: buffered + in-flight; dropped fetches keep their credit until they return
  assign used      = {1'b0, buf_cnt} + {1'b0, drop_q};
  assign pop       = head_vld && id_ready && !redirect;
  // a pop this cycle frees a slot, which keeps a 1-cycle memory at full rate
  assign credit_ok = (used < (CW+1)'(BUF_DEPTH)) || pop;
  assign imem_req  = run_q && (hold_q || (!redirect && credit_ok));
  assign imem_addr = hold_q ? hold_addr_q : pc_q;

  assign gnt_fire  = imem_req && imem_gnt;
  assign gnt_drop  = gnt_fire && (redirect || stale_q);
  assign alloc     = gnt_fire && !gnt_drop;
  assign fill      = imem_rvalid && !redirect && (drop_q == '0);

  always_comb begin
    run_d       = 1'b1;
    hold_d      = imem_req && !imem_gnt;
    hold_addr_d = imem_addr;
    stale_d     = hold_d && (stale_q || redirect);
    pc_d        = pc_q;
    if (redirect)   pc_d = align_pc(redirect_pc);
    else if (alloc) pc_d = pc_q + 32'(IMEM_WORD_BYTES);

    // responses are in order: drops are always older than live slots,
    // so any rvalid while drops remain (or during a redirect) is discarded
    drop_d = drop_q;
    if (redirect) drop_d = drop_d + buf_unfilled;
    if (gnt_drop) drop_d = drop_d + CNT_ONE;
    if (imem_rvalid && (redirect || drop_q != '0)) drop_d = drop_d - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      hold_q      <= 1'b0;
      stale_q     <= 1'b0;
      pc_q        <= RESET_PC;
      hold_addr_q <= RESET_PC;
      drop_q      <= '0;
    end else begin
      run_q       <= run_d;
      hold_q      <= hold_d;
      stale_q     <= stale_d;
      pc_q        <= pc_d;
      hold_addr_q <= hold_addr_d;
      drop_q      <= drop_d;
    end
  end

  if_fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .alloc     (alloc),
    .alloc_pc  (imem_addr),
    .fill      (fill),
    .fill_inst (imem_rdata),
    .pop       (pop),
    .head_vld  (head_vld),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (buf_cnt),
    .unfilled  (buf_unfilled)
  );

  // payload forced to zero when invalid so reset/flush values are clean
  assign id_valid = head_vld;
  assign id_inst  = head_vld ? head_inst : '0;
  assign id_pc    = head_vld ? head_pc : '0;
  assign id_pc4   = head_vld ? head_pc + 32'(IMEM_WORD_BYTES) : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(pop);
    stall_cnt_d = stall_cnt_q + 32'(id_valid && !id_ready);
    flush_cnt_d = flush_cnt_q + 32'(redirect);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: an instruction-memory responder with random
// grant/latency, a random ID consumer, and a reference model of the
// instruction stream ID must see (sequential from the last redirect target).
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int gnt_pct, rv_pct, rdy_pct;
  int cyc_no = 0;
  int pops = 0;
  int grants = 0;
  logic [31:0] model_pc;
  logic [31:0] rq_addr[$];
  int          rq_cyc[$];
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  bit          obs_vld, obs_req;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic chk_reset();
    chk("rst_req",  32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_vld",  32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_pc",   id_pc, 32'd0);
    chk("rst_pc4",  id_pc4, 32'd0);
  endtask

  // one clock cycle: drive inputs, observe, update model, advance
  task automatic cyc();
    id_ready    = ($urandom_range(99) < rdy_pct);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rq_addr.size() > 0 && rq_cyc[0] < cyc_no && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memw(rq_addr[0]);
    end
    imem_gnt = 1'b0;
    #1;
    if (imem_req && $urandom_range(99) < gnt_pct) imem_gnt = 1'b1;
    #1;
    if (prev_pend) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, prev_addr);
    end
    if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    obs_vld = id_valid;
    obs_req = imem_req;
    if (id_valid && id_ready && !redirect) begin
      chk("id_pc", id_pc, model_pc);
      chk("id_inst", id_inst, memw(model_pc));
      chk("id_pc4", id_pc4, model_pc + 32'd4);
      model_pc = model_pc + 32'd4;
      pops++;
    end
    if (imem_req && imem_gnt) begin
      rq_addr.push_back(imem_addr);
      rq_cyc.push_back(cyc_no);
      grants++;
    end
    if (imem_rvalid) begin
      void'(rq_addr.pop_front());
      void'(rq_cyc.pop_front());
    end
    chk("inflight_max", 32'(rq_addr.size() <= DEPTH), 32'd1);
    if (redirect) model_pc = redirect_pc & ~32'd3;
    prev_pend = imem_req && !imem_gnt;
    prev_addr = imem_addr;
    @(posedge clk);
    #1;
    cyc_no++;
    redirect = 1'b0;
  endtask

  initial begin
    int g0, p0;
    bit v1, v2, v3;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    model_pc = RST_PC;
    #12;
    chk_reset();
    rst_n = 1'b1;
    #1;
    chk("req_at_release", 32'(imem_req), 32'd0);
    @(posedge clk); #1;

    // ID stalled: exactly DEPTH grants, then request drops
    rdy_pct = 0; gnt_pct = 100; rv_pct = 100;
    g0 = grants;
    cyc();
    chk("first_req", 32'(obs_req), 32'd1);
    repeat (5) cyc();
    chk("full_grants", 32'(grants - g0), 32'(DEPTH));
    chk("full_req_low", 32'(obs_req), 32'd0);
    chk("full_vld", 32'(obs_vld), 32'd1);

    // release ID: stream FFF8, FFFC, 0, 4, ... at one per cycle
    rdy_pct = 100;
    repeat (4) cyc();
    p0 = pops;
    repeat (16) cyc();
    chk("throughput", 32'(pops - p0), 32'd16);

    // redirect from idle: id_valid appears at t+3
    rdy_pct = 0;
    repeat (6) cyc();
    chk("drained", 32'(rq_addr.size()), 32'd0);
    rdy_pct = 100;
    redirect = 1'b1; redirect_pc = 32'h0000_2000;
    cyc();
    cyc(); v1 = obs_vld;
    cyc(); v2 = obs_vld;
    cyc(); v3 = obs_vld;
    chk("redir_t1", 32'(v1), 32'd0);
    chk("redir_t2", 32'(v2), 32'd0);
    chk("redir_t3", 32'(v3), 32'd1);

    // redirect with two fetches in flight: both dropped, next pc 0x100
    repeat (6) cyc();
    rv_pct = 0;
    repeat (2) cyc();
    chk("inflight_at_redir", 32'(rq_addr.size()), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cyc();
    rv_pct = 100;
    p0 = pops;
    repeat (12) cyc();
    chk("after_drop_pops", 32'(pops > p0), 32'd1);

    // grant withheld with a redirect in the middle of the wait
    repeat (4) cyc();
    gnt_pct = 0;
    cyc(); cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_4008;
    cyc();
    cyc();
    gnt_pct = 100;
    p0 = pops;
    repeat (12) cyc();
    chk("after_stale_pops", 32'(pops > p0), 32'd1);

    // random traffic with occasional redirects
    rdy_pct = 70; gnt_pct = 60; rv_pct = 60;
    p0 = pops;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(99) < 4) begin
        redirect = 1'b1;
        redirect_pc = $urandom;
      end
      cyc();
    end
    chk("rand_progress", 32'(pops - p0 > 50), 32'd1);

    // asynchronous reset with responses outstanding
    rv_pct = 0; gnt_pct = 100; rdy_pct = 100;
    repeat (3) cyc();
    chk("pend_before_rst", 32'(rq_addr.size() > 0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset();
    rq_addr.delete();
    rq_cyc.delete();
    prev_pend = 1'b0;
    model_pc = RST_PC;
    redirect = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    chk("req_at_release2", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    rv_pct = 100;
    p0 = pops;
    repeat (8) cyc();
    chk("restart_pops", 32'(pops - p0), 32'd6);

    rdy_pct = 60; gnt_pct = 70; rv_pct = 50;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(99) < 5) begin
        redirect = 1'b1;
        redirect_pc = $urandom;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
